// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter driving a registered common data bus (CDB).
//
// Functional units present results on req_valid/req_tag/req_data and keep them
// stable until accepted. Exactly one (or no) requester is granted per cycle via
// the combinational req_ready vector; the winning tag/data/source index are
// broadcast on the CDB one cycle later.
//
// Ports:
//   clock         rising-edge clock
//   reset_n       synchronous active-low reset
//   req_valid     per-requester result valid
//   req_tag       packed per-requester tags, requester i at [i*TAG_W +: TAG_W]
//   req_data      packed per-requester data, requester i at [i*DATA_W +: DATA_W]
//   req_ready     one-hot or zero grant (combinational)
//   flush         branch-mispredict flush, blocks all grants this cycle
//   cdb_valid     broadcast valid (registered)
//   cdb_tag       broadcast tag (registered, held when idle)
//   cdb_data      broadcast data (registered, held when idle)
//   cdb_src       index of the winning requester (registered, held when idle)
//   conflict_cnt  saturating count of non-flush cycles with 2+ requesters valid
module cdb_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned TAG_W   = 4,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned SRC_W   = 2
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic                        flush,
   output logic                        cdb_valid,
   output logic [TAG_W-1:0]            cdb_tag,
   output logic [DATA_W-1:0]           cdb_data,
   output logic [SRC_W-1:0]            cdb_src,
   output logic [15:0]                 conflict_cnt
);

   typedef enum logic [0:0] {StIdle, StBcast} state_e;

   state_e              state_q, state_d;
   logic [SRC_W-1:0]    ptr_q, ptr_d;
   logic [TAG_W-1:0]    cdb_tag_q, cdb_tag_d;
   logic [DATA_W-1:0]   cdb_data_q, cdb_data_d;
   logic [SRC_W-1:0]    cdb_src_q, cdb_src_d;
   logic [15:0]         cnt_q, cnt_d;

   logic [NUM_REQ-1:0]  grant;
   logic                xfer;
   int unsigned         idx;
   logic [SRC_W-1:0]    win_src;
   logic [TAG_W-1:0]    win_tag;
   logic [DATA_W-1:0]   win_data;
   logic                multi;

   // Round-robin search starting at ptr_q; the first valid requester wins.
   // Reset and flush both suppress every grant.
   always_comb begin
      grant = '0;
      xfer  = 1'b0;
      idx   = 0;
      if (reset_n && !flush) begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr_q) + k) % NUM_REQ;
            if (!xfer && req_valid[idx[SRC_W-1:0]]) begin
               xfer                  = 1'b1;
               grant[idx[SRC_W-1:0]] = 1'b1;
            end
         end
      end
   end

   // Select the winner's payload from the one-hot grant.
   always_comb begin
      win_src  = '0;
      win_tag  = '0;
      win_data = '0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (grant[j]) begin
            win_src  = SRC_W'(j);
            win_tag  = req_tag[j*TAG_W +: TAG_W];
            win_data = req_data[j*DATA_W +: DATA_W];
         end
      end
   end

   assign multi = ($countones(req_valid) > 1);

   always_comb begin
      state_d    = xfer ? StBcast : StIdle;
      ptr_d      = ptr_q;
      cdb_tag_d  = cdb_tag_q;
      cdb_data_d = cdb_data_q;
      cdb_src_d  = cdb_src_q;
      cnt_d      = cnt_q;
      if (xfer) begin
         ptr_d      = SRC_W'((32'(win_src) + 1) % NUM_REQ);
         cdb_tag_d  = win_tag;
         cdb_data_d = win_data;
         cdb_src_d  = win_src;
      end
      if (!flush && multi && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         ptr_q      <= '0;
         cdb_tag_q  <= '0;
         cdb_data_q <= '0;
         cdb_src_q  <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cdb_tag_q  <= cdb_tag_d;
         cdb_data_q <= cdb_data_d;
         cdb_src_q  <= cdb_src_d;
         cnt_q      <= cnt_d;
      end
   end

   assign req_ready    = grant;
   assign cdb_valid    = (state_q == StBcast);
   assign cdb_tag      = cdb_tag_q;
   assign cdb_data     = cdb_data_q;
   assign cdb_src      = cdb_src_q;
   assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

   logic          clock;
   logic          reset_n;
   logic [3:0]    req_valid;
   logic [15:0]   req_tag;
   logic [127:0]  req_data;
   logic [3:0]    req_ready;
   logic          flush;
   logic          cdb_valid;
   logic [3:0]    cdb_tag;
   logic [31:0]   cdb_data;
   logic [1:0]    cdb_src;
   logic [15:0]   conflict_cnt;

   cdb_arbiter #(
      .NUM_REQ (4),
      .TAG_W   (4),
      .DATA_W  (32),
      .SRC_W   (2)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_tag      (req_tag),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .flush        (flush),
      .cdb_valid    (cdb_valid),
      .cdb_tag      (cdb_tag),
      .cdb_data     (cdb_data),
      .cdb_src      (cdb_src),
      .conflict_cnt (conflict_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]  valid;
      logic        fl;
      logic        rn;
      logic [3:0]  exp_rdy;
      logic [15:0] exp_cnt;
   } vec_t;

   typedef struct {
      logic        v;
      logic [3:0]  tag;
      logic [31:0] data;
      logic [1:0]  src;
   } bcast_t;

   vec_t   vecs[23];
   bcast_t sb_q[$];

   logic [3:0]  tags  [4];
   logic [31:0] datas [4];

   int n_total;
   int n_pass;

   logic [3:0]  hold_tag;
   logic [31:0] hold_data;
   logic [1:0]  hold_src;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Drive one cycle, check grant mid-cycle, then check the broadcast after the edge.
   task automatic step(input int n, input vec_t v);
      bcast_t e;
      bcast_t got;
      req_valid = v.valid;
      flush     = v.fl;
      reset_n   = v.rn;
      #3;
      chk($sformatf("v%0d req_ready", n), 32'(req_ready), 32'(v.exp_rdy));
      if (!v.rn) begin
         hold_tag = '0; hold_data = '0; hold_src = '0;
         e.v = 1'b0;
      end else if (v.exp_rdy != 4'b0000) begin
         for (int i = 0; i < 4; i++) begin
            if (v.exp_rdy[i]) begin
               hold_tag  = tags[i];
               hold_data = datas[i];
               hold_src  = 2'(i);
            end
         end
         e.v = 1'b1;
      end else begin
         e.v = 1'b0;
      end
      e.tag = hold_tag; e.data = hold_data; e.src = hold_src;
      sb_q.push_back(e);
      @(posedge clock);
      #1;
      if (sb_q.size() == 0) begin
         chk($sformatf("v%0d scoreboard", n), 32'(0), 32'(1));
      end else begin
         got = sb_q.pop_front();
         chk($sformatf("v%0d cdb_valid", n), 32'(cdb_valid), 32'(got.v));
         chk($sformatf("v%0d cdb_tag", n), 32'(cdb_tag), 32'(got.tag));
         chk($sformatf("v%0d cdb_data", n), cdb_data, got.data);
         chk($sformatf("v%0d cdb_src", n), 32'(cdb_src), 32'(got.src));
      end
      chk($sformatf("v%0d conflict_cnt", n), 32'(conflict_cnt), 32'(v.exp_cnt));
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      hold_tag = '0; hold_data = '0; hold_src = '0;
      tags[0] = 4'h9; datas[0] = 32'h1111_0000;
      tags[1] = 4'h5; datas[1] = 32'h2222_5555;
      tags[2] = 4'h3; datas[2] = 32'h0000_00AA;
      tags[3] = 4'hC; datas[3] = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) begin
         req_tag[i*4 +: 4]   = tags[i];
         req_data[i*32 +: 32] = datas[i];
      end

      //           valid    fl    rn    exp_rdy  exp_cnt
      vecs[0]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 16'd0};  // reset
      vecs[1]  = '{4'b0100, 1'b0, 1'b1, 4'b0100, 16'd0};  // single req r2, ptr->3
      vecs[2]  = '{4'b0000, 1'b0, 1'b1, 4'b0000, 16'd0};  // idle, outputs held
      vecs[3]  = '{4'b1001, 1'b0, 1'b1, 4'b1000, 16'd1};  // ptr 3 -> grant 3, wrap
      vecs[4]  = '{4'b1001, 1'b0, 1'b1, 4'b0001, 16'd2};  // ptr 0 -> grant 0
      vecs[5]  = '{4'b1111, 1'b1, 1'b1, 4'b0000, 16'd2};  // flush while bcast live
      vecs[6]  = '{4'b1111, 1'b0, 1'b1, 4'b0010, 16'd3};  // ptr still 1
      vecs[7]  = '{4'b1111, 1'b0, 1'b1, 4'b0100, 16'd4};
      vecs[8]  = '{4'b1111, 1'b0, 1'b1, 4'b1000, 16'd5};
      vecs[9]  = '{4'b0110, 1'b0, 1'b1, 4'b0010, 16'd6};  // ptr 0, skips idle r0
      vecs[10] = '{4'b0110, 1'b0, 1'b1, 4'b0100, 16'd7};
      vecs[11] = '{4'b0011, 1'b0, 1'b1, 4'b0001, 16'd8};  // ptr 3, wraps to r0
      vecs[12] = '{4'b0010, 1'b0, 1'b0, 4'b0000, 16'd0};  // reset drops pending r1
      vecs[13] = '{4'b0011, 1'b0, 1'b1, 4'b0001, 16'd1};  // r0 busy -> r0 first
      vecs[14] = '{4'b0010, 1'b0, 1'b1, 4'b0010, 16'd1};
      vecs[15] = '{4'b0010, 1'b0, 1'b0, 4'b0000, 16'd0};  // reset again
      vecs[16] = '{4'b0010, 1'b0, 1'b1, 4'b0010, 16'd0};  // r0 idle -> r1 first
      vecs[17] = '{4'b1111, 1'b0, 1'b0, 4'b0000, 16'd0};  // all valid from reset
      vecs[18] = '{4'b1111, 1'b0, 1'b1, 4'b0001, 16'd1};
      vecs[19] = '{4'b1111, 1'b0, 1'b1, 4'b0010, 16'd2};
      vecs[20] = '{4'b1111, 1'b0, 1'b1, 4'b0100, 16'd3};
      vecs[21] = '{4'b1111, 1'b0, 1'b1, 4'b1000, 16'd4};
      vecs[22] = '{4'b1111, 1'b0, 1'b1, 4'b0001, 16'd5};

      reset_n   = 1'b0;
      flush     = 1'b0;
      req_valid = '0;
      @(posedge clock);
      #1;

      for (int n = 0; n < 23; n++) step(n, vecs[n]);

      // Continuous contention up to the saturation point (count is 5 here).
      repeat (65529) @(posedge clock);
      #1;
      chk("sat reach FFFE", 32'(conflict_cnt), 32'h0000_FFFE);
      chk("sat one-hot ready", 32'($countones(req_ready)), 32'd1);
      chk("sat cdb_valid", 32'(cdb_valid), 32'd1);
      @(posedge clock);
      #1;
      chk("sat reach FFFF", 32'(conflict_cnt), 32'h0000_FFFF);
      repeat (3) @(posedge clock);
      #1;
      chk("sat hold FFFF", 32'(conflict_cnt), 32'h0000_FFFF);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
